// File: rtl/if_stage_fetch.sv
// rtl/if_stage_fetch.sv - instruction fetch stage with PC, single-outstanding imem request and IF/ID register
module if_stage_fetch #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hazard,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_rvalid,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_instr
);

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_KILL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [DATA_W-1:0] id_instr_q, id_instr_d;
    logic [ADDR_W-1:0] pc_plus4;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        imem_req   = 1'b0;
        imem_addr  = pc_q;

        if (branch_taken) begin
            pc_d       = branch_addr;
            id_valid_d = 1'b0;
            id_pc_d    = '0;
            id_instr_d = NOP_INSTR;
            hold_d     = NOP_INSTR;
            // A request still in flight must be drained before refetching.
            state_d    = (state_q == S_WAIT && !imem_rvalid) ? S_KILL : S_ISSUE;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    imem_req = 1'b1;
                    state_d  = S_WAIT;
                    if (!hazard) begin
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (hazard) begin
                            hold_d  = imem_rdata;
                            state_d = S_HOLD;
                        end else begin
                            id_valid_d = 1'b1;
                            id_instr_d = imem_rdata;
                            id_pc_d    = pc_plus4;
                            pc_d       = pc_plus4;
                            imem_req   = 1'b1;
                            imem_addr  = pc_plus4;
                        end
                    end else if (!hazard) begin
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!hazard) begin
                        id_valid_d = 1'b1;
                        id_instr_d = hold_q;
                        id_pc_d    = pc_plus4;
                        pc_d       = pc_plus4;
                        hold_d     = NOP_INSTR;
                        state_d    = S_ISSUE;
                    end
                end
                S_KILL: begin
                    if (imem_rvalid) begin
                        state_d = S_ISSUE;
                    end
                    if (!hazard) begin
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                    end
                end
                default: state_d = S_ISSUE;
            endcase
        end

        if (!rst_n) begin
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_ISSUE;
            pc_q       <= RESET_PC;
            hold_q     <= NOP_INSTR;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// tb/tb_if_stage_fetch.sv - scoreboard bench for if_stage_fetch with variable-latency memory models
module tb_if_stage_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_n_b, hazard, branch_taken;
    logic [31:0] branch_addr;

    logic        imem_req, imem_rvalid, id_valid;
    logic [31:0] imem_addr, imem_rdata, id_pc, id_instr;
    logic        imem_req_b, imem_rvalid_b, id_valid_b;
    logic [31:0] imem_addr_b, imem_rdata_b, id_pc_b, id_instr_b;

    int          lat;
    int          cnt;
    logic [31:0] paddr;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    if_stage_fetch dut_a (
        .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr)
    );

    if_stage_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .hazard(1'b0), .branch_taken(1'b0),
        .branch_addr(32'h0), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_rdata(imem_rdata_b), .imem_rvalid(imem_rvalid_b), .id_valid(id_valid_b),
        .id_pc(id_pc_b), .id_instr(id_instr_b)
    );

    // Memory A: returns the address as data after 'lat' cycles.
    always @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= 0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            imem_rvalid <= 1'b0;
            if (cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= paddr;
                cnt         <= 0;
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end
            if (imem_req) begin
                paddr <= imem_addr;
                if (lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= imem_addr;
                end else begin
                    cnt <= lat - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n_b) begin
            imem_rvalid_b <= 1'b0;
            imem_rdata_b  <= 32'h0;
        end else begin
            imem_rvalid_b <= imem_req_b;
            imem_rdata_b  <= imem_addr_b;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] pc, input logic [31:0] instr);
        q_a.push_back('{pc: pc, instr: instr});
    endtask

    task automatic push_b(input logic [31:0] pc, input logic [31:0] instr);
        q_b.push_back('{pc: pc, instr: instr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a new IF/ID presentation pops one expected entry.
    logic        mon_en = 1'b0;
    logic        pv_a = 1'b0, pv_b = 1'b0;
    logic [31:0] pp_a, pi_a, pp_b, pi_b;

    always @(negedge clk) begin
        if (mon_en) begin
            if (id_valid === 1'b1) begin
                if (pv_a !== 1'b1 || id_pc !== pp_a || id_instr !== pi_a) begin
                    if (q_a.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_unexpected: got pc %h instr %h expected none", id_pc, id_instr);
                    end else begin
                        ea = q_a.pop_front();
                        chk("a_id_pc", id_pc, ea.pc);
                        chk("a_id_instr", id_instr, ea.instr);
                    end
                end
            end else begin
                chk("a_bubble_instr", id_instr, 32'h0);
            end
            if (id_valid_b === 1'b1) begin
                if (pv_b !== 1'b1 || id_pc_b !== pp_b || id_instr_b !== pi_b) begin
                    if (q_b.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected: got pc %h instr %h expected none", id_pc_b, id_instr_b);
                    end else begin
                        eb = q_b.pop_front();
                        chk("b_id_pc", id_pc_b, eb.pc);
                        chk("b_id_instr", id_instr_b, eb.instr);
                    end
                end
            end else begin
                chk("b_bubble_instr", id_instr_b, 32'h0);
            end
            pv_a <= id_valid;
            pp_a <= id_pc;
            pi_a <= id_instr;
            pv_b <= id_valid_b;
            pp_b <= id_pc_b;
            pi_b <= id_instr_b;
        end
    end

    task automatic chk_id_a(input string name, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr);
        chk({name, "_valid"}, {31'b0, id_valid}, {31'b0, v});
        chk({name, "_pc"}, id_pc, pc);
        chk({name, "_instr"}, id_instr, instr);
    endtask

    task automatic chk_req_a(input string name, input logic r, input logic [31:0] addr);
        chk({name, "_req"}, {31'b0, imem_req}, {31'b0, r});
        if (r) chk({name, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0; hazard = 1'b0; branch_taken = 1'b0;
        branch_addr = 32'h0; lat = 1;
        tick(); tick();
        mon_en = 1'b1;
        @(negedge clk);
        chk_id_a("reset", 1'b0, 32'h0, 32'h0);
        chk_req_a("reset", 1'b0, 32'h0);
        chk("reset_b_req", {31'b0, imem_req_b}, 32'h0);
        chk("reset_b_valid", {31'b0, id_valid_b}, 32'h0);

        // Streaming at latency 1, both instances; B wraps from FFFF_FFFC to 0.
        push_a(32'h4, 32'h0); push_a(32'h8, 32'h4); push_a(32'hC, 32'h8);
        push_b(32'h0, 32'hFFFF_FFFC); push_b(32'h4, 32'h0); push_b(32'h8, 32'h4);
        tick();
        rst_n = 1'b1; rst_n_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_req_a("stream", 1'b1, 32'(4 * i));
            chk("stream_b_req", {31'b0, imem_req_b}, 32'h1);
            chk("stream_b_addr", imem_addr_b, 32'hFFFF_FFFC + 32'(4 * i));
            tick();
        end

        // Cycle 4: hazard while response arrives in WAIT -> HOLD for 3 cycles.
        rst_n_b = 1'b0;
        hazard = 1'b1;
        push_a(32'h10, 32'hC); push_a(32'h14, 32'h10); push_a(32'h18, 32'h14);
        push_a(32'h1C, 32'h18); push_a(32'h20, 32'h1C);
        @(negedge clk); chk_req_a("hold_enter", 1'b0, 32'h0); tick();
        @(negedge clk); chk_id_a("frozen1", 1'b1, 32'hC, 32'h8); tick();
        @(negedge clk); chk_id_a("frozen2", 1'b1, 32'hC, 32'h8); tick();
        hazard = 1'b0;
        @(negedge clk); chk_id_a("frozen3", 1'b1, 32'hC, 32'h8);
        chk_req_a("hold_noreq", 1'b0, 32'h0); tick();
        @(negedge clk); chk_req_a("after_hold", 1'b1, 32'h10); tick();
        @(negedge clk); chk("after_hold_bubble", {31'b0, id_valid}, 32'h0);
        chk_req_a("after_hold_pipe", 1'b1, 32'h14); tick();
        tick(); tick();

        // Cycle 12: request to 0x20 at latency 3, branch while outstanding.
        lat = 3;
        @(negedge clk); chk_req_a("req_20", 1'b1, 32'h20); tick();
        branch_taken = 1'b1; branch_addr = 32'h100;
        @(negedge clk); chk_req_a("branch_suppress", 1'b0, 32'h0); tick();
        branch_taken = 1'b0;
        push_a(32'h104, 32'h100);
        @(negedge clk); chk_id_a("flush", 1'b0, 32'h0, 32'h0);
        chk_req_a("kill_noreq", 1'b0, 32'h0); tick();
        @(negedge clk); chk_req_a("kill_stale", 1'b0, 32'h0); tick();
        @(negedge clk); chk_req_a("refetch", 1'b1, 32'h100);
        chk("refetch_bubble", {31'b0, id_valid}, 32'h0); tick();
        tick(); tick();
        @(negedge clk); chk_req_a("target_pipe", 1'b1, 32'h104);
        chk("target_wait_bubble", {31'b0, id_valid}, 32'h0); tick();
        tick(); tick();

        // Cycle 22: enter HOLD, then branch and hazard together.
        hazard = 1'b1;
        @(negedge clk); chk_req_a("hold2_enter", 1'b0, 32'h0); tick();
        branch_taken = 1'b1; branch_addr = 32'h100;
        @(negedge clk); chk_req_a("hold2_branch", 1'b0, 32'h0); tick();
        branch_taken = 1'b0; hazard = 1'b0; lat = 1;
        push_a(32'h104, 32'h100); push_a(32'h108, 32'h104); push_a(32'h10C, 32'h108);
        @(negedge clk); chk_req_a("hold2_refetch", 1'b1, 32'h100);
        chk_id_a("hold2_flush", 1'b0, 32'h0, 32'h0); tick();
        tick(); tick(); tick();

        // Cycle 28: one-cycle reset mid-WAIT.
        rst_n = 1'b0;
        push_a(32'h4, 32'h0); push_a(32'h8, 32'h4);
        @(negedge clk); chk_req_a("midreset", 1'b0, 32'h0); tick();
        rst_n = 1'b1;
        @(negedge clk); chk_id_a("post_reset", 1'b0, 32'h0, 32'h0);
        chk_req_a("post_reset", 1'b1, 32'h0); tick();
        tick(); tick();
        rst_n = 1'b0;
        tick(); tick();

        chk("a_queue_empty", q_a.size(), 32'h0);
        chk("b_queue_empty", q_b.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
